// File: rtl/alu_pkg.sv
// Shared types and constants for the multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_XOR   = 4'b0011,
    OP_NOR   = 4'b0100,
    OP_SLL   = 4'b0101,
    OP_SUB   = 4'b0110,
    OP_SLT   = 4'b0111,
    OP_SRL   = 4'b1000,
    OP_SRA   = 4'b1001,
    OP_MULLO = 4'b1010,
    OP_MULHU = 4'b1011,
    OP_DIVU  = 4'b1100,
    OP_REMU  = 4'b1101,
    OP_ILL0  = 4'b1110,
    OP_ILL1  = 4'b1111
  } alucontrol_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int FLAG_W       = 5;
  localparam int FLAG_ZERO    = 0;
  localparam int FLAG_C       = 1;
  localparam int FLAG_V       = 2;
  localparam int FLAG_DBZ     = 3;
  localparam int FLAG_ILLEGAL = 4;

  function automatic logic is_muldiv(alucontrol_t op);
    return (op == OP_MULLO) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

  function automatic logic is_div(alucontrol_t op);
    return (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_iter.sv
// Iterative 1-bit/cycle datapath: shift-add multiply and restoring unsigned divide.
// The first iteration runs on the start edge straight from the operand inputs, so
// the count reaches N after N edges and done rises one cycle before the caller
// captures hi/lo. Multiply: {hi,lo} = A*B. Divide: lo = quotient, hi = remainder.
module alu_iter #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         is_div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N + 1);

  logic [CW-1:0] cnt_q;
  logic [N-1:0]  hi_q, lo_q, b_q;
  logic          div_q;

  logic [N-1:0]  src_hi, src_lo, src_b;
  logic          src_div;
  logic [N:0]    sum, shifted;
  logic [N-1:0]  diff;
  logic [N-1:0]  nxt_hi, nxt_lo;
  logic          active;

  // One iteration step, fed from the operand inputs on the start cycle.
  always_comb begin
    src_hi  = start ? '0 : hi_q;
    src_lo  = start ? a : lo_q;
    src_b   = start ? b : b_q;
    src_div = start ? is_div : div_q;
    sum     = '0;
    shifted = '0;
    diff    = '0;
    nxt_hi  = src_hi;
    nxt_lo  = src_lo;
    if (src_div) begin
      shifted = {src_hi, src_lo[N-1]};
      if (shifted >= {1'b0, src_b}) begin
        // remainder after subtract is below B, so N bits hold it exactly
        diff   = shifted[N-1:0] - src_b;
        nxt_hi = diff;
        nxt_lo = {src_lo[N-2:0], 1'b1};
      end else begin
        nxt_hi = shifted[N-1:0];
        nxt_lo = {src_lo[N-2:0], 1'b0};
      end
    end else begin
      sum = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : {(N+1){1'b0}});
      {nxt_hi, nxt_lo} = {sum, src_lo[N-1:1]};
    end
  end

  assign active = start | ((cnt_q != '0) && (cnt_q != CW'(N)));
  assign done   = (cnt_q == CW'(N));
  assign hi     = hi_q;
  assign lo     = lo_q;

  // Iteration registers and step counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (active) begin
      hi_q <= nxt_hi;
      lo_q <= nxt_lo;
      if (start) begin
        b_q   <= b;
        div_q <= is_div;
        cnt_q <= CW'(1);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops, iterative MUL/DIV,
// valid/ready on both sides, registered result and status flags.
//
// state | meaning
// IDLE  | ready to accept an op
// BUSY  | iterative mul/div in progress
// DONE  | Z/flags valid, held until out_ready
module alu_mc
  import alu_pkg::*;
#(
  parameter int N          = 32,
  parameter bit HAS_MULDIV = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      A,
  input  logic [N-1:0]      B,
  input  logic [3:0]        alucontrol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      Z,
  output logic [FLAG_W-1:0] flags
);

  localparam int SW = $clog2(N);

  state_t      state_q, state_d;
  alucontrol_t op_in, op_q;
  logic        bzero_q;
  logic        accept, start;

  logic [N:0]        add_w, sub_w;
  logic [SW-1:0]     shamt;
  logic [N-1:0]      simple_z, iter_z;
  logic [FLAG_W-1:0] simple_flags, iter_flags;

  logic         iter_done;
  logic [N-1:0] iter_hi, iter_lo;

  assign op_in     = alucontrol_t'(alucontrol);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready;
  assign start     = accept & HAS_MULDIV & is_muldiv(op_in);

  // Single-cycle result and flags from the live operands.
  always_comb begin
    add_w        = {1'b0, A} + {1'b0, B};
    sub_w        = {1'b0, A} + {1'b0, ~B} + (N+1)'(1);
    shamt        = B[SW-1:0];
    simple_z     = '0;
    simple_flags = '0;
    case (op_in)
      OP_AND: simple_z = A & B;
      OP_OR:  simple_z = A | B;
      OP_XOR: simple_z = A ^ B;
      OP_NOR: simple_z = ~(A | B);
      OP_SLL: simple_z = A << shamt;
      OP_SRL: simple_z = A >> shamt;
      OP_SRA: simple_z = $signed(A) >>> shamt;
      OP_SLT: simple_z = ($signed(A) < $signed(B)) ? N'(1) : '0;
      OP_ADD: begin
        simple_z             = add_w[N-1:0];
        simple_flags[FLAG_C] = add_w[N];
        simple_flags[FLAG_V] = (A[N-1] == B[N-1]) && (add_w[N-1] != A[N-1]);
      end
      OP_SUB: begin
        simple_z             = sub_w[N-1:0];
        simple_flags[FLAG_C] = sub_w[N];
        simple_flags[FLAG_V] = (A[N-1] != B[N-1]) && (sub_w[N-1] != A[N-1]);
      end
      // reserved codes, and mul/div when the iterative unit is absent
      default: simple_flags[FLAG_ILLEGAL] = 1'b1;
    endcase
    simple_flags[FLAG_ZERO] = (simple_z == '0);
  end

  // Select the iterative result for the captured op.
  always_comb begin
    case (op_q)
      OP_MULLO: iter_z = iter_lo;
      OP_MULHU: iter_z = iter_hi;
      OP_DIVU:  iter_z = iter_lo;
      default:  iter_z = iter_hi;
    endcase
    iter_flags            = '0;
    iter_flags[FLAG_DBZ]  = is_div(op_q) & bzero_q;
    iter_flags[FLAG_ZERO] = (iter_z == '0);
  end

  generate
    if (HAS_MULDIV) begin : g_iter
      alu_iter #(.N(N)) u_iter (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .is_div (is_div(op_in)),
        .a      (A),
        .b      (B),
        .done   (iter_done),
        .hi     (iter_hi),
        .lo     (iter_lo)
      );
    end else begin : g_no_iter
      assign iter_done = 1'b0;
      assign iter_hi   = '0;
      assign iter_lo   = '0;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = start ? BUSY : DONE;
      BUSY: if (iter_done) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Op capture and result/flag registers; held untouched while in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_AND;
      bzero_q <= 1'b0;
      Z       <= '0;
      flags   <= '0;
    end else if (accept) begin
      op_q    <= op_in;
      bzero_q <= (B == '0);
      if (!start) begin
        Z     <= simple_z;
        flags <= simple_flags;
      end
    end else if ((state_q == BUSY) && iter_done) begin
      Z     <= iter_z;
      flags <= iter_flags;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc (N=32, MUL/DIV present): directed vector table, randomized
// ops against an arithmetic reference model, backpressure and reset-abort sequences.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  alucontrol = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] Z;
  logic [4:0]  flags;

  int tests = 0;
  int fails = 0;

  alu_mc #(.N(32), .HAS_MULDIV(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .A          (A),
    .B          (B),
    .alucontrol (alucontrol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .Z          (Z),
    .flags      (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    logic [4:0]  f;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the op definitions; flags {illegal,dbz,v,c,zero}.
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] z, output logic [4:0] f, output int lat);
    longint      sa, sb, r;
    logic [63:0] p;
    logic [4:0]  sh;
    logic        c, v, ill, dbz;
    c = 0; v = 0; ill = 0; dbz = 0; lat = 1; z = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    case (op)
      4'd0: z = a & b;
      4'd1: z = a | b;
      4'd2: begin
        z = a + b;
        c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF;
        r = sa + sb;
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd3: z = a ^ b;
      4'd4: z = ~(a | b);
      4'd5: z = a << sh;
      4'd6: begin
        z = a - b;
        c = (a >= b);
        r = sa - sb;
        v = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      end
      4'd7: z = (sa < sb) ? 32'd1 : 32'd0;
      4'd8: z = a >> sh;
      4'd9: z = $signed(a) >>> sh;
      4'd10: begin p = {32'b0, a} * {32'b0, b}; z = p[31:0];  lat = 33; end
      4'd11: begin p = {32'b0, a} * {32'b0, b}; z = p[63:32]; lat = 33; end
      4'd12: begin z = (b == 0) ? 32'hFFFF_FFFF : a / b; dbz = (b == 0); lat = 33; end
      4'd13: begin z = (b == 0) ? a : a % b;            dbz = (b == 0); lat = 33; end
      default: ill = 1;
    endcase
    f = {ill, dbz, v, c, (z == 0)};
  endfunction

  // Issue one op, measure cycles from accept to out_valid, then retire it.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] z, output logic [4:0] f, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_before_issue", {63'b0, in_ready}, 64'd1);
    A = a; B = b; alucontrol = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; A = $urandom; B = $urandom; alucontrol = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    z = Z; f = flags;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] z, ez;
    logic [4:0]  f, ef;
    int          lat, elat;
    logic        seen;
    logic [3:0]  op;
    logic [31:0] a, b;

    vecs[0]  = '{4'h2, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 5'b00100, 1};
    vecs[1]  = '{4'h6, 32'd5,         32'd5,         32'h0,         5'b00011, 1};
    vecs[2]  = '{4'h7, 32'hFFFF_FFFF, 32'h1,         32'h1,         5'b00000, 1};
    vecs[3]  = '{4'hB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5'b00000, 33};
    vecs[4]  = '{4'hA, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         5'b00000, 33};
    vecs[5]  = '{4'hC, 32'd100,       32'd7,         32'd14,        5'b00000, 33};
    vecs[6]  = '{4'hD, 32'd100,       32'd7,         32'd2,         5'b00000, 33};
    vecs[7]  = '{4'hC, 32'd9,         32'd0,         32'hFFFF_FFFF, 5'b01000, 33};
    vecs[8]  = '{4'hD, 32'd9,         32'd0,         32'd9,         5'b01000, 33};
    vecs[9]  = '{4'hE, 32'd3,         32'd4,         32'h0,         5'b10001, 1};
    vecs[10] = '{4'h9, 32'h8000_0000, 32'd4,         32'hF800_0000, 5'b00000, 1};
    vecs[11] = '{4'h5, 32'd1,         32'd36,        32'h10,        5'b00000, 1};
    vecs[12] = '{4'h2, 32'hFFFF_FFFF, 32'd1,         32'h0,         5'b00011, 1};
    vecs[13] = '{4'h6, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 5'b00110, 1};
    vecs[14] = '{4'h4, 32'd0,         32'd0,         32'hFFFF_FFFF, 5'b00000, 1};
    vecs[15] = '{4'hC, 32'd7,         32'd100,       32'h0,         5'b00001, 33};
    vecs[16] = '{4'h6, 32'd0,         32'd1,         32'hFFFF_FFFF, 5'b00000, 1};

    // reset state
    #1;
    check("rst_out_valid", {63'b0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'b0, in_ready},  64'd1);
    check("rst_Z",         {32'b0, Z},         64'd0);
    check("rst_flags",     {59'b0, flags},     64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;

    // directed vectors
    for (int i = 0; i < 17; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, z, f, lat);
      check($sformatf("vec%0d_Z", i),     {32'b0, z},   {32'b0, vecs[i].z});
      check($sformatf("vec%0d_flags", i), {59'b0, f},   {59'b0, vecs[i].f});
      check($sformatf("vec%0d_lat", i),   64'(lat),     64'(vecs[i].lat));
    end

    // randomized ops against the model
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 40));
        default: b = $urandom;
      endcase
      model(op, a, b, ez, ef, elat);
      do_op(op, a, b, z, f, lat);
      check($sformatf("rnd%0d_op%0d_Z", i, op),     {32'b0, z}, {32'b0, ez});
      check($sformatf("rnd%0d_op%0d_flags", i, op), {59'b0, f}, {59'b0, ef});
      check($sformatf("rnd%0d_op%0d_lat", i, op),   64'(lat),   64'(elat));
    end

    // backpressure: hold DONE for 5 cycles, competing in_valid must be ignored
    @(negedge clk);
    A = 32'd3; B = 32'd4; alucontrol = 4'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    check("bp_out_valid", {63'b0, out_valid}, 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      A = 32'd1; B = 32'd1; alucontrol = 4'h6; in_valid = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp%0d_Z", i),        {32'b0, Z},         64'd7);
      check($sformatf("bp%0d_flags", i),    {59'b0, flags},     64'd0);
      check($sformatf("bp%0d_in_ready", i), {63'b0, in_ready},  64'd0);
      check($sformatf("bp%0d_valid", i),    {63'b0, out_valid}, 64'd1);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("bp_release_valid", {63'b0, out_valid}, 64'd0);
    check("bp_release_ready", {63'b0, in_ready},  64'd1);
    @(posedge clk); #1;
    check("bp_no_ghost_accept", {63'b0, out_valid}, 64'd0);

    // reset 10 cycles into a divide aborts it
    @(negedge clk);
    A = 32'd1000; B = 32'd3; alucontrol = 4'hC; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    check("abort_busy_ready", {63'b0, in_ready}, 64'd0);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_out_valid", {63'b0, out_valid}, 64'd0);
    check("abort_in_ready",  {63'b0, in_ready},  64'd1);
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", {63'b0, seen}, 64'd0);
    do_op(4'h2, 32'd2, 32'd3, z, f, lat);
    check("post_abort_Z",     {32'b0, z}, 64'd5);
    check("post_abort_flags", {59'b0, f}, 64'd0);
    check("post_abort_lat",   64'(lat),   64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
